dmem_responder: RTL and testbench
=================================

# dmem_responder

Single-port data memory responder answering the core's data-memory request interface (active-low CEN/WEN/OEN, 7-bit word address, 32-bit write/read data). It sits between the single-cycle core and the data array. After reset it runs a clear sequence, then serves one read or write per cycle. `ready` is used at top level to hold the core in reset until the clear completes.

## Interface
- DW, 32, data width in bits
- AW, 7, word-address width
- DEPTH, 128, number of words; must satisfy DEPTH ≤ 2^AW
- RD_REG, 0, read mode:
  - 0 = combinational read, for the single-cycle core
  - 1 = registered read, one cycle latency
- INIT_VAL, 32'h0, value written to every word by the clear sequence
- clk  in  1  clock, rising-edge active
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- CEN  in  1  chip enable, active low
- WEN  in  1  write enable, active low (0 = write, 1 = read); meaningful only when CEN=0
- OEN  in  1  output enable, active low
- A  in  AW  word address
- D  in  DW  write data
- Q  out  DW  read data
- ready  out  1  clear sequence done; accesses are honoured
- err  out  1  sticky flag: access attempted while ready=0

## Operation
- States: ST_CLEAR, ST_READY.
- Reset (rst=1, asynchronous): state=ST_CLEAR, clear counter=0, ready=0, err=0, Q register=0. Q output=0.
- ST_CLEAR:
  - Each rising edge writes INIT_VAL to mem[cnt], then cnt++.
  - On the edge that writes cnt=DEPTH-1, go to ST_READY.
  - Any cycle with CEN=0 sets err. The access is dropped: no array write, Q=0.
- ST_READY:
  - CEN=1: idle. No array change. RD_REG=1 Q register holds.
  - CEN=0, WEN=0: mem[A] <= D at the rising edge. RD_REG=1 Q register holds.
  - CEN=0, WEN=1, RD_REG=0: Q = mem[A] combinationally, same cycle.
  - CEN=0, WEN=1, RD_REG=1: Q register <= mem[A] at the rising edge.
  - A ≥ DEPTH: write dropped; read data = 0.
- OEN gating, combinational, both modes: Q = 0 whenever OEN=1.
  - RD_REG=0: Q is also 0 unless ready=1, CEN=0 and WEN=1.
- err clears only on rst. ST_READY never returns to ST_CLEAR except through rst.
- Reset mid-clear or mid-operation: the sequence restarts from cnt=0. Array contents are unspecified until the clear completes.

## Timing
- Clear takes DEPTH cycles. ready rises at the end of cycle DEPTH after the rst deassertion edge (cycle 128 by default).
- Write latency: data is visible to a read in the next cycle.
  - Read of the same address in the next cycle returns the new D, in both modes.
- Read latency:
  - RD_REG=0: 0 cycles, combinational from A.
  - RD_REG=1: 1 cycle. Q is valid in the cycle after the request and holds until the next read.
- Single port: no simultaneous read and write. WEN selects one.

## Structure
- Shared package `dmem_pkg` holds:
  - state enum dmem_state_t {ST_CLEAR, ST_READY}
  - default DW/AW/DEPTH constants
  - localparam for active-low levels (ACT=1'b0)
- Sub-module `dmem_init_seq`: clear counter and FSM, producing clear_we, clear_addr and ready.
- Top level holds the array, the write mux (clear vs. core port), read path and err.

## Test plan
- Reset then idle: ready=0 through cycle 127, ready=1 at cycle 128. Read of every address returns INIT_VAL=0; err=0.
- Write then read (RD_REG=0):
  - Write A=5, D=32'hDEADBEEF, then read A=5 with OEN=0: Q=32'hDEADBEEF in the same cycle.
  - Same read with OEN=1: Q=0.
- Registered read (RD_REG=1):
  - Write A=127, D=32'h1234_5678.
  - Read A=127: Q=32'h1234_5678 one cycle later.
  - Then idle cycles (CEN=1): Q holds 32'h1234_5678.
- Access during clear: CEN=0, WEN=0, A=3, D=32'hFF at cycle 10.
  - Expect err=1 (sticky); after ready, mem[3] reads 0.
  - rst clears err.
- Reset mid-operation:
  - Write A=9, D=7, then assert rst for 1 cycle.
  - ready drops to 0 immediately and rises 128 cycles after deassertion; mem[9] reads 0.
- Back-to-back writes to A=0..3 with D=A+1, then reads of A=0..3: return 1,2,3,4. CEN=1 cycles interleaved cause no change.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - dmem_state_t : clear / ready phase of the responder
//   - DW_DEF, AW_DEF, DEPTH_DEF : default geometry
//   - ACT : asserted level of the core's active-low strobes (CEN/WEN/OEN)
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dmem_state_t;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 7;
  localparam int DEPTH_DEF = 128;

  localparam logic ACT = 1'b0;

endpackage

// File: rtl/dmem_init_seq.sv
// Post-reset clear sequencer for the data memory.
// Walks every word address once, requesting a write of the init value,
// then settles in ST_READY until the next reset.
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear_we   out  array write request from the clear sequence
//   clear_addr out  word address being cleared
//   ready      out  clear finished; core accesses are honoured
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  dmem_state_t   state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clear_we  = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        clear_we = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        // Leave on the edge that writes the final word.
        if (cnt == LAST) state_nxt = ST_READY;
      end
      ST_READY: ;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  assign clear_addr = cnt;
  assign ready      = (state == ST_READY);

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory answering the core's active-low request port.
// After reset the array is filled with INIT_VAL, then one read or write
// is served per cycle. Reads are combinational (RD_REG=0) or registered
// with one cycle of latency (RD_REG=1).
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   CEN   in   chip enable, active low
//   WEN   in   write enable, active low (0 = write, 1 = read)
//   OEN   in   output enable, active low
//   A     in   word address
//   D     in   write data
//   Q     out  read data (0 when not driven)
//   ready out  clear sequence complete
//   err   out  sticky: access attempted before ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DW       = DW_DEF,
  parameter int          AW       = AW_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter bit          RD_REG   = 1'b0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic          ready,
  output logic          err
);

  logic          clear_we;
  logic [AW-1:0] clear_addr;
  logic          in_range;
  logic          wr_req, rd_req;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [DW-1:0] mem [DEPTH];

  dmem_init_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .ready      (ready)
  );

  // A full-size array makes every address valid; otherwise bound-check.
  if (DEPTH >= (1 << AW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_partial
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    assign in_range = ({1'b0, A} < DEPTH_W);
  end

  assign wr_req = ready && (CEN == ACT) && (WEN == ACT);
  assign rd_req = ready && (CEN == ACT) && (WEN != ACT);

  // The clear sequence owns the write port until ready; core accesses
  // during that window are dropped.
  assign we    = clear_we || (wr_req && in_range);
  assign waddr = clear_we ? clear_addr : A;
  assign wdata = clear_we ? INIT_VAL : D;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = in_range ? mem[A] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         err <= 1'b0;
    else if (!ready && (CEN == ACT)) err <= 1'b1;
  end

  if (RD_REG) begin : g_rd_reg
    logic [DW-1:0] q_reg;
    // Holds the last read value across idle and write cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         q_reg <= '0;
      else if (rd_req) q_reg <= rdata;
    end
    assign Q = (OEN == ACT) ? q_reg : '0;
  end else begin : g_rd_comb
    assign Q = ((OEN == ACT) && rd_req) ? rdata : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one combinational-read and one
// registered-read instance share the same request stimulus and are
// checked against a behavioural model of the memory.
module tb_dmem_responder;

  localparam int          DW    = 32;
  localparam int          AW    = 7;
  localparam int          DEPTH = 128;
  localparam logic [31:0] INIT  = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b1, wen = 1'b1, oen = 1'b1;
  logic [AW-1:0] a   = '0;
  logic [DW-1:0] d   = '0;
  logic [DW-1:0] q0, q1;
  logic          ready0, ready1, err0, err1;

  always #5 clk = ~clk;

  dmem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_REG(1'b0), .INIT_VAL(INIT)) dut0 (
    .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d),
    .Q(q0), .ready(ready0), .err(err0));

  dmem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_REG(1'b1), .INIT_VAL(INIT)) dut1 (
    .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d),
    .Q(q1), .ready(ready1), .err(err1));

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: clear countdown, word array, sticky error, read latch.
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left;
  logic          err_m;
  logic [DW-1:0] q1_m;

  function automatic logic ready_m();
    return (clr_left == 0);
  endfunction

  function automatic logic [DW-1:0] exp_q0();
    if (!oen && ready_m() && !cen && wen) return mem_m[a];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_q1();
    return oen ? '0 : q1_m;
  endfunction

  task automatic drive(input logic c, input logic w, input logic o,
                       input logic [AW-1:0] aa, input logic [DW-1:0] dd);
    cen = c; wen = w; oen = o; a = aa; d = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (clr_left > 0) begin
        if (!cen) err_m = 1'b1;
        clr_left--;
        if (clr_left == 0) foreach (mem_m[i]) mem_m[i] = INIT;
      end else if (!cen) begin
        if (!wen) mem_m[a] = d;
        else      q1_m     = mem_m[a];
      end
    end
    #1;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    clr_left = DEPTH;
    err_m = 1'b0;
    q1_m = '0;
    #1;
  endtask

  task automatic release_rst();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_until_ready();
    drive(1, 1, 0, '0, '0);
    for (int k = 0; k < 2 * DEPTH && clr_left > 0; k++) tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 0, '0, '0);
    assert_rst();
    compared++;
    if (ready0 !== 1'b0 || ready1 !== 1'b0 || err0 !== 1'b0 || err1 !== 1'b0 ||
        q0 !== '0 || q1 !== '0) begin
      mismatched++;
      $display("FAIL reset_state: ready=%b/%b err=%b/%b q=%h/%h, required all 0",
               ready0, ready1, err0, err1, q0, q1);
    end
    release_rst();
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      compared++;
      if (ready0 !== ready_m() || ready1 !== ready_m()) begin
        mismatched++;
        $display("FAIL ready_rise cycle %0d: ready=%b/%b, required %b", k, ready0, ready1, ready_m());
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 0, AW'(i), $urandom);
      #4;
      compared++;
      if (q0 !== exp_q0() || q0 !== INIT) begin
        mismatched++;
        $display("FAIL init_read_comb A=%0d: got %h, required %h", i, q0, INIT);
      end
      tick();
      compared++;
      if (q1 !== exp_q1()) begin
        mismatched++;
        $display("FAIL init_read_reg A=%0d: got %h, required %h", i, q1, exp_q1());
      end
    end
    compared++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      mismatched++;
      $display("FAIL init_err: got %b/%b, required 0", err0, err1);
    end
  endtask

  task automatic test_write_read();
    drive(0, 0, 0, 7'd5, 32'hDEADBEEF);
    tick();
    drive(0, 1, 0, 7'd5, '0);
    #4;
    compared++;
    if (q0 !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL wr_rd_comb: got %h, required %h", q0, 32'hDEADBEEF);
    end
    tick();
    compared++;
    if (q1 !== exp_q1()) begin
      mismatched++;
      $display("FAIL wr_rd_reg: got %h, required %h", q1, exp_q1());
    end
    drive(0, 1, 1, 7'd5, '0);
    #4;
    compared++;
    if (q0 !== '0 || q1 !== '0) begin
      mismatched++;
      $display("FAIL oen_gate: got %h/%h, required 0", q0, q1);
    end
    tick();
  endtask

  task automatic test_registered();
    drive(0, 0, 0, 7'd127, 32'h1234_5678);
    tick();
    drive(0, 1, 0, 7'd127, '0);
    tick();
    compared++;
    if (q1 !== 32'h1234_5678) begin
      mismatched++;
      $display("FAIL reg_read: got %h, required %h", q1, 32'h1234_5678);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, AW'($urandom), $urandom);
      #4;
      compared++;
      if (q1 !== exp_q1() || q0 !== exp_q0()) begin
        mismatched++;
        $display("FAIL reg_hold idle %0d: got %h/%h, required %h/%h", k, q0, q1, exp_q0(), exp_q1());
      end
      tick();
    end
  endtask

  task automatic test_clear_access();
    drive(1, 1, 0, '0, '0);
    assert_rst();
    release_rst();
    for (int k = 0; k < 9; k++) tick();
    drive(0, 0, 0, 7'd3, 32'hFF);
    tick();
    compared++;
    if (err0 !== 1'b1 || err1 !== 1'b1) begin
      mismatched++;
      $display("FAIL clear_err_set: got %b/%b, required 1", err0, err1);
    end
    idle_until_ready();
    compared++;
    if (err0 !== err_m || err1 !== err_m || ready0 !== 1'b1 || ready1 !== 1'b1) begin
      mismatched++;
      $display("FAIL clear_err_sticky: err=%b/%b ready=%b/%b, required err=%b ready=1",
               err0, err1, ready0, ready1, err_m);
    end
    drive(0, 1, 0, 7'd3, '0);
    #4;
    compared++;
    if (q0 !== INIT) begin
      mismatched++;
      $display("FAIL clear_drop_comb: got %h, required %h", q0, INIT);
    end
    tick();
    compared++;
    if (q1 !== exp_q1()) begin
      mismatched++;
      $display("FAIL clear_drop_reg: got %h, required %h", q1, exp_q1());
    end
    drive(1, 1, 0, '0, '0);
    assert_rst();
    compared++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_clears_err: got %b/%b, required 0", err0, err1);
    end
    release_rst();
    idle_until_ready();
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 7'd9, 32'd7);
    tick();
    drive(1, 1, 0, '0, '0);
    assert_rst();
    compared++;
    if (ready0 !== 1'b0 || ready1 !== 1'b0 || q1 !== '0) begin
      mismatched++;
      $display("FAIL mid_rst_drop: ready=%b/%b q1=%h, required 0", ready0, ready1, q1);
    end
    release_rst();
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      compared++;
      if (ready0 !== ready_m() || ready1 !== ready_m()) begin
        mismatched++;
        $display("FAIL mid_rst_ready cycle %0d: got %b/%b, required %b", k, ready0, ready1, ready_m());
      end
    end
    drive(0, 1, 0, 7'd9, '0);
    #4;
    compared++;
    if (q0 !== INIT) begin
      mismatched++;
      $display("FAIL mid_rst_mem: got %h, required %h", q0, INIT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, AW'(i), DW'(i + 1));
      tick();
      if (i == 1) begin
        drive(1, 0, 0, AW'(i), 32'hBAD0_0000);
        tick();
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, AW'(i), $urandom);
      #4;
      compared++;
      if (q0 !== DW'(i + 1)) begin
        mismatched++;
        $display("FAIL b2b_comb A=%0d: got %h, required %h", i, q0, DW'(i + 1));
      end
      tick();
      compared++;
      if (q1 !== DW'(i + 1)) begin
        mismatched++;
        $display("FAIL b2b_reg A=%0d: got %h, required %h", i, q1, DW'(i + 1));
      end
      drive(1, 1, 0, AW'(i), '0);
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom),
            $urandom);
      #4;
      compared++;
      if (q0 !== exp_q0()) begin
        mismatched++;
        $display("FAIL rand_comb #%0d A=%0d: got %h, required %h", n, a, q0, exp_q0());
      end
      tick();
      compared++;
      if (q1 !== exp_q1() || err0 !== err_m || err1 !== err_m ||
          ready0 !== ready_m() || ready1 !== ready_m()) begin
        mismatched++;
        $display("FAIL rand_reg #%0d: q1=%h err=%b/%b ready=%b/%b, required q1=%h err=%b ready=%b",
                 n, q1, err0, err1, ready0, ready1, exp_q1(), err_m, ready_m());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_registered();
    test_back_to_back();
    test_random();
    test_clear_access();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
